// File: rtl/ritc_scan_edge_finder.sv
// Reduces one phase sweep of scanner results to the first filtered rise/fall step positions.
// Optional RITC_SCAN_EDGE_HIGH_COUNT_EN builds the count of samples equal to 1.
module ritc_scan_edge_finder #(
    parameter int CNT_WIDTH  = 12,
    parameter int FILTER_LEN = 3
) (
    input  logic                 CLK,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic                 scan_valid_i,
    input  logic                 scan_bit_i,
    input  logic                 scan_done_i,
    output logic                 busy_o,
    output logic                 result_valid_o,
    output logic                 rise_found_o,
    output logic                 fall_found_o,
    output logic [CNT_WIDTH-1:0] rise_pos_o,
    output logic [CNT_WIDTH-1:0] fall_pos_o,
    output logic [CNT_WIDTH-1:0] step_count_o,
    output logic                 overflow_o,
    output logic [CNT_WIDTH-1:0] high_count_o
);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
    localparam logic [3:0]           RUN_LEN = 4'(FILTER_LEN);

    typedef enum logic [1:0] {ST_IDLE, ST_FIRST, ST_TRACK, ST_FLUSH} state_t;

    state_t               r_state, w_state_next;
    logic                 r_result_valid, w_result_next;
    logic                 r_pend, r_cap_vld, r_cap_bit;
    logic [CNT_WIDTH-1:0] r_cap_idx;
    logic [CNT_WIDTH-1:0] r_step, w_step_inc;
    logic                 r_overflow, r_flush_wait;
    logic                 r_ref_vld, r_ref;
    logic [3:0]           r_run, w_run_inc;
    logic [CNT_WIDTH-1:0] r_run_start, w_run_start;
    logic                 r_rise_found, r_fall_found;
    logic [CNT_WIDTH-1:0] r_rise_pos, r_fall_pos;
    logic                 w_sweeping, w_accept, w_end_sweep;

    assign w_sweeping  = (r_state == ST_FIRST) || (r_state == ST_TRACK);
    assign w_accept    = w_sweeping && scan_valid_i && !start_i;
    assign w_end_sweep = w_sweeping && scan_done_i && !start_i;
    assign w_step_inc  = (r_step == CNT_MAX) ? r_step : r_step + CNT_ONE;
    assign w_run_inc   = r_run + 4'd1;
    assign w_run_start = (r_run == 4'd0) ? r_cap_idx : r_run_start;

    always_ff @(posedge CLK) begin
        if (rst_i) begin
            r_state        <= ST_IDLE;
            r_result_valid <= 1'b0;
        end else begin
            r_state        <= w_state_next;
            r_result_valid <= w_result_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_result_next = 1'b0;
        case (r_state)
            ST_IDLE:  if (start_i) w_state_next = ST_FIRST;
            ST_FIRST: begin
                if (start_i)          w_state_next = ST_FIRST;
                else if (scan_done_i) w_state_next = ST_FLUSH;
                else if (r_cap_vld)   w_state_next = ST_TRACK;
            end
            ST_TRACK: begin
                if (start_i)          w_state_next = ST_FIRST;
                else if (scan_done_i) w_state_next = ST_FLUSH;
            end
            ST_FLUSH: begin
                if (start_i) begin
                    w_state_next = ST_FIRST;
                end else if (!r_flush_wait) begin
                    w_state_next  = ST_IDLE;
                    w_result_next = 1'b1;
                end
            end
            default:  w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (rst_i || start_i) begin
            r_pend       <= 1'b0;
            r_cap_vld    <= 1'b0;
            r_cap_bit    <= 1'b0;
            r_cap_idx    <= '0;
            r_step       <= '0;
            r_overflow   <= 1'b0;
            r_flush_wait <= 1'b0;
            r_ref_vld    <= 1'b0;
            r_ref        <= 1'b0;
            r_run        <= '0;
            r_run_start  <= '0;
            r_rise_found <= 1'b0;
            r_fall_found <= 1'b0;
            r_rise_pos   <= '0;
            r_fall_pos   <= '0;
        end else begin
            r_pend    <= w_accept;
            r_cap_vld <= r_pend;
            if (r_pend) begin
                r_cap_bit <= scan_bit_i;
                r_cap_idx <= r_step;
                r_step    <= w_step_inc;
                if (w_step_inc == CNT_MAX) r_overflow <= 1'b1;
            end
            // A sample in flight at the end of the sweep costs one extra flush cycle.
            if (w_end_sweep)             r_flush_wait <= scan_valid_i || r_pend;
            else if (r_state == ST_FLUSH) r_flush_wait <= 1'b0;
            if (r_cap_vld) begin
                if (!r_ref_vld) begin
                    r_ref_vld <= 1'b1;
                    r_ref     <= r_cap_bit;
                    r_run     <= '0;
                end else if (r_cap_bit == r_ref) begin
                    r_run <= '0;
                end else if (w_run_inc == RUN_LEN) begin
                    r_ref <= r_cap_bit;
                    r_run <= '0;
                    if (r_cap_bit && !r_rise_found) begin
                        r_rise_found <= 1'b1;
                        r_rise_pos   <= w_run_start;
                    end
                    if (!r_cap_bit && !r_fall_found) begin
                        r_fall_found <= 1'b1;
                        r_fall_pos   <= w_run_start;
                    end
                end else begin
                    r_run       <= w_run_inc;
                    r_run_start <= w_run_start;
                end
            end
        end
    end

`ifdef RITC_SCAN_EDGE_HIGH_COUNT_EN
    logic [CNT_WIDTH-1:0] r_high;

    always_ff @(posedge CLK) begin
        if (rst_i || start_i)
            r_high <= '0;
        else if (r_cap_vld && r_cap_bit && (r_high != CNT_MAX))
            r_high <= r_high + CNT_ONE;
    end

    assign high_count_o = r_high;
`else
    assign high_count_o = '0;
`endif

    assign busy_o         = (r_state != ST_IDLE);
    assign result_valid_o = r_result_valid;
    assign rise_found_o   = r_rise_found;
    assign fall_found_o   = r_fall_found;
    assign rise_pos_o     = r_rise_pos;
    assign fall_pos_o     = r_fall_pos;
    assign step_count_o   = r_step;
    assign overflow_o     = r_overflow;

endmodule

// File: tb/tb_ritc_scan_edge_finder.sv
// Randomized bench for ritc_scan_edge_finder: a wide (12-bit) and a narrow (4-bit, saturating)
// instance share one stimulus stream and are checked against a lookahead model of the sweep.
module tb_ritc_scan_edge_finder;
    localparam int CW_A  = 12;
    localparam int CW_B  = 4;
    localparam int FL    = 3;
    localparam int MAX_A = (1 << CW_A) - 1;
    localparam int MAX_B = (1 << CW_B) - 1;

    logic CLK = 1'b0;
    logic rst_i, start_i, scan_valid_i, scan_bit_i, scan_done_i;

    logic            a_busy_o, a_result_valid_o, a_rise_found_o, a_fall_found_o, a_overflow_o;
    logic [CW_A-1:0] a_rise_pos_o, a_fall_pos_o, a_step_count_o, a_high_count_o;
    logic            b_busy_o, b_result_valid_o, b_rise_found_o, b_fall_found_o, b_overflow_o;
    logic [CW_B-1:0] b_rise_pos_o, b_fall_pos_o, b_step_count_o, b_high_count_o;

    int checks   = 0;
    int failures = 0;
    bit smp[$];
    bit prev_v = 1'b0;
    bit prev_b = 1'b0;

    always #5 CLK = ~CLK;

    ritc_scan_edge_finder #(.CNT_WIDTH(CW_A), .FILTER_LEN(FL)) u_dut_a (
        .CLK(CLK), .rst_i(rst_i), .start_i(start_i), .scan_valid_i(scan_valid_i),
        .scan_bit_i(scan_bit_i), .scan_done_i(scan_done_i), .busy_o(a_busy_o),
        .result_valid_o(a_result_valid_o), .rise_found_o(a_rise_found_o),
        .fall_found_o(a_fall_found_o), .rise_pos_o(a_rise_pos_o), .fall_pos_o(a_fall_pos_o),
        .step_count_o(a_step_count_o), .overflow_o(a_overflow_o), .high_count_o(a_high_count_o)
    );

    ritc_scan_edge_finder #(.CNT_WIDTH(CW_B), .FILTER_LEN(FL)) u_dut_b (
        .CLK(CLK), .rst_i(rst_i), .start_i(start_i), .scan_valid_i(scan_valid_i),
        .scan_bit_i(scan_bit_i), .scan_done_i(scan_done_i), .busy_o(b_busy_o),
        .result_valid_o(b_result_valid_o), .rise_found_o(b_rise_found_o),
        .fall_found_o(b_fall_found_o), .rise_pos_o(b_rise_pos_o), .fall_pos_o(b_fall_pos_o),
        .step_count_o(b_step_count_o), .overflow_o(b_overflow_o), .high_count_o(b_high_count_o)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Drives one cycle; the scan bit always belongs to the previous cycle's valid.
    task automatic drive(input bit v, input bit b, input bit d, input bit s);
        scan_bit_i   = prev_v ? prev_b : 1'($urandom);
        scan_valid_i = v;
        scan_done_i  = d;
        start_i      = s;
        prev_v       = v && !s;
        prev_b       = b;
        tick();
    endtask

    // Edge at i when the FILTER_LEN samples starting at i all differ from the current level.
    function automatic void model(input int maxv, output int rf, output int ff, output int rp,
                                  output int fp, output int sc, output int ov, output int hc);
        int n, ones, i;
        bit level, ok;
        n = smp.size();
        ones = 0; rf = 0; ff = 0; rp = 0; fp = 0;
        foreach (smp[k]) ones += int'(smp[k]);
        sc = (n < maxv) ? n : maxv;
        ov = (n >= maxv) ? 1 : 0;
`ifdef RITC_SCAN_EDGE_HIGH_COUNT_EN
        hc = (ones < maxv) ? ones : maxv;
`else
        hc = 0;
`endif
        if (n > 0) begin
            level = smp[0];
            i = 1;
            while (i < n) begin
                ok = (i + FL <= n);
                for (int j = 0; j < FL && ok; j++)
                    if (smp[i+j] == level) ok = 1'b0;
                if (ok) begin
                    if (!level && !rf) begin
                        rf = 1; rp = (i < maxv) ? i : maxv;
                    end else if (level && !ff) begin
                        ff = 1; fp = (i < maxv) ? i : maxv;
                    end
                    level = !level;
                    i += FL;
                end else begin
                    i++;
                end
            end
        end
    endfunction

    task automatic check_zero(input string tag);
        check_val({tag, ".busy"},  {a_busy_o, b_busy_o}, 0);
        check_val({tag, ".rv"},    {a_result_valid_o, b_result_valid_o}, 0);
        check_val({tag, ".found"}, {a_rise_found_o, a_fall_found_o, b_rise_found_o, b_fall_found_o}, 0);
        check_val({tag, ".a_pos"}, {a_rise_pos_o, a_fall_pos_o}, 0);
        check_val({tag, ".b_pos"}, {b_rise_pos_o, b_fall_pos_o}, 0);
        check_val({tag, ".steps"}, {a_step_count_o, b_step_count_o}, 0);
        check_val({tag, ".ovf"},   {a_overflow_o, b_overflow_o}, 0);
        check_val({tag, ".high"},  {a_high_count_o, b_high_count_o}, 0);
    endtask

    task automatic finish_and_check(input string name, input int exp_lat);
        int lat;
        int rf, ff, rp, fp, sc, ov, hc;
        int sc_a;
        lat = 1;
        while (!a_result_valid_o && lat < 8) begin
            drive(0, 0, 0, 0);
            lat++;
        end
        check_val({name, ".lat"}, lat, exp_lat);
        check_val({name, ".b_rv"}, b_result_valid_o, 1);
        model(MAX_A, rf, ff, rp, fp, sc, ov, hc);
        sc_a = sc;
        check_val({name, ".a_rise_found"}, a_rise_found_o, rf);
        check_val({name, ".a_fall_found"}, a_fall_found_o, ff);
        check_val({name, ".a_rise_pos"},   a_rise_pos_o, rp);
        check_val({name, ".a_fall_pos"},   a_fall_pos_o, fp);
        check_val({name, ".a_steps"},      a_step_count_o, sc);
        check_val({name, ".a_ovf"},        a_overflow_o, ov);
        check_val({name, ".a_high"},       a_high_count_o, hc);
        $display("sweep %s n=%0d lat=%0d rise=%0d@%0d fall=%0d@%0d steps=%0d high=%0d",
                 name, smp.size(), lat, rf, rp, ff, fp, sc, hc);
        model(MAX_B, rf, ff, rp, fp, sc, ov, hc);
        check_val({name, ".b_rise_found"}, b_rise_found_o, rf);
        check_val({name, ".b_fall_found"}, b_fall_found_o, ff);
        check_val({name, ".b_rise_pos"},   b_rise_pos_o, rp);
        check_val({name, ".b_fall_pos"},   b_fall_pos_o, fp);
        check_val({name, ".b_steps"},      b_step_count_o, sc);
        check_val({name, ".b_ovf"},        b_overflow_o, ov);
        check_val({name, ".b_high"},       b_high_count_o, hc);
        drive(0, 0, 0, 0);
        check_val({name, ".pulse_idle"}, {a_result_valid_o, b_result_valid_o, a_busy_o, b_busy_o}, 0);
        check_val({name, ".hold"}, a_step_count_o, sc_a);
    endtask

    // done_gap: -1 = done with the last valid, 0 = next cycle, k = k idle cycles between.
    task automatic sweep(input string name, input int gap_max, input int done_gap, input bit start_extra);
        int n, exp_lat;
        n = smp.size();
        drive(start_extra, 1'b1, start_extra, 1'b1);
        for (int k = 0; k < n; k++) begin
            repeat ($urandom_range(0, gap_max)) drive(0, 0, 0, 0);
            drive(1, smp[k], (k == n - 1) && (done_gap < 0), 0);
        end
        if (n == 0 || done_gap >= 0) begin
            repeat ((done_gap > 0) ? done_gap : 0) drive(0, 0, 0, 0);
            drive(0, 0, 1, 0);
        end
        exp_lat = (n > 0 && done_gap <= 0) ? 3 : 2;
        finish_and_check(name, exp_lat);
    endtask

    task automatic gen_runs(input int n);
        bit lvl;
        smp.delete();
        lvl = 1'($urandom);
        while (smp.size() < n) begin
            int len;
            len = $urandom_range(1, 5);
            for (int j = 0; j < len && smp.size() < n; j++) smp.push_back(lvl);
            lvl = !lvl;
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i = 1'b1; start_i = 1'b0; scan_valid_i = 1'b0; scan_bit_i = 1'b0; scan_done_i = 1'b0;
        tick();
        tick();
        check_zero("reset");
        rst_i = 1'b0;
        drive(0, 0, 0, 0);

        smp.delete();
        for (int k = 0; k < 100; k++) smp.push_back(k >= 40 && k < 80);
        sweep("clean", 1, 2, 1'b0);

        smp.delete();
        for (int k = 0; k < 100; k++) smp.push_back((k == 10) || (k == 11) || (k >= 50));
        sweep("glitch", 0, 1, 1'b0);

        smp.delete();
        for (int k = 0; k < 20; k++) smp.push_back(1'b1);
        sweep("overflow", 0, 0, 1'b0);

        gen_runs(10);
        sweep("done_with_valid", 0, -1, 1'b0);

        smp.delete();
        sweep("start_vs_valid", 0, 1, 1'b1);

        gen_runs(8);
        sweep("start_vs_done", 1, 1, 1'b1);

        smp.delete();
        sweep("empty", 0, -1, 1'b0);

        // Abort at step 30, then reset at step 5 of the restarted sweep.
        drive(0, 0, 0, 1);
        for (int k = 0; k < 30; k++) drive(1, 1'($urandom), 0, 0);
        drive(0, 0, 0, 1);
        check_val("abort.steps", a_step_count_o, 0);
        check_val("abort.busy", {a_busy_o, b_busy_o}, 3);
        for (int k = 0; k < 5; k++) begin
            drive(1, 1'($urandom), 0, 0);
            check_val("abort.no_rv", {a_result_valid_o, b_result_valid_o}, 0);
        end
        $display("abort at step 30 steps_after=%0d", a_step_count_o);
        rst_i = 1'b1;
        drive(1, 1'b1, 0, 0);
        rst_i = 1'b0;
        check_zero("rst_mid");
        drive(0, 0, 1, 0);
        for (int k = 0; k < 4; k++) begin
            drive(0, 0, 0, 0);
            check_val("rst_mid.no_rv", {a_result_valid_o, b_result_valid_o, a_busy_o, b_busy_o}, 0);
        end
        $display("reset at step 5 busy=%0d", a_busy_o);

        for (int t = 0; t < 40; t++) begin
            gen_runs($urandom_range(0, 60));
            sweep($sformatf("rand%0d", t), $urandom_range(0, 2), int'($urandom_range(0, 3)) - 1,
                  1'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
